// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, decoder phase encodings, fault codes and sequencer states.
package cpu_pkg;

  localparam logic [4:0] OpStp = 5'b00000;
  localparam logic [4:0] OpJmp = 5'b00001;
  localparam logic [4:0] OpSta = 5'b00010;
  localparam logic [4:0] OpLda = 5'b00011;
  localparam logic [4:0] OpJms = 5'b00100;
  localparam logic [4:0] OpBbl = 5'b00101;

  // Four-bit prefixes; the low opcode bit is an operand select.
  localparam logic [3:0] PfxJeq = 4'b1100;
  localparam logic [3:0] PfxMul = 4'b1101;
  localparam logic [3:0] PfxLdr = 4'b1110;

  localparam logic [2:0] PhNone  = 3'b000;
  localparam logic [2:0] PhFetch = 3'b001;
  localparam logic [2:0] PhExec1 = 3'b010;
  localparam logic [2:0] PhExec2 = 3'b100;

  typedef enum logic [1:0] {
    FaultNone       = 2'b00,
    FaultOverflow   = 2'b01,
    FaultUnderflow  = 2'b10,
    FaultMulTimeout = 2'b11
  } fault_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec1,
    StMulw,
    StExec2,
    StHalt
  } seq_state_e;

  function automatic logic is_two_phase(input logic [4:0] op);
    return (op == OpLda) || (op[4:1] == PfxLdr);
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return op[4:1] == PfxMul;
  endfunction

endpackage

// File: rtl/ret_stack_tracker.sv
// Return-stack occupancy counter with overflow/underflow pre-check on the fetched opcode.
module ret_stack_tracker
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [4:0]         op,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow
);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full, empty;

  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    depth_d = depth_q;
    if (push && !full) begin
      depth_d = depth_q + 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth     = depth_q;
  assign overflow  = (op == OpJms) && full;
  assign underflow = (op == OpBbl) && empty;

endmodule

// File: rtl/cpu_sequencer.sv
// Control-state sequencer: one-hot decoder phases, IR latch, fetch/mul wait states, stack faults.
// Define CPU_SEQ_MUL_TIMEOUT_EN to fault (code 11) when the multiplier exceeds MUL_TIMEOUT cycles.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = 3,
  parameter int unsigned MUL_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [4:0]         inst_in,
  output logic [4:0]         ir,
  output logic               ir_load,
  output logic [2:0]         state,
  output logic               mul_start,
  input  logic               mul_done,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic               halted,
  output logic               busy
);

  if ((2 ** DEPTH_W) <= STACK_DEPTH || MUL_TIMEOUT == 0) begin : g_param_chk
    $error("cpu_sequencer: DEPTH_W too narrow for STACK_DEPTH, or MUL_TIMEOUT is zero");
  end

  seq_state_e  state_q, state_d, boundary_st;
  logic [4:0]  ir_q, ir_d;
  logic        fault_q, fault_d;
  fault_code_e code_q, code_d;
  logic        push, pop, overflow, underflow;

  ret_stack_tracker #(
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .op       (inst_in),
    .depth    (depth),
    .overflow (overflow),
    .underflow(underflow)
  );

`ifdef CPU_SEQ_MUL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MUL_TIMEOUT + 1);
  logic [CntW-1:0] mul_cnt_q, mul_cnt_d;

  always_comb begin
    mul_cnt_d = '0;
    if (state_q == StMulw && !mul_done) begin
      mul_cnt_d = mul_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt_q <= '0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
      fault_q <= 1'b0;
      code_q  <= FaultNone;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    fault_d     = fault_q;
    code_d      = code_q;
    boundary_st = halt_req ? StHalt : StFetch;
    unique case (state_q)
      StIdle: if (run) state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          ir_d = inst_in;
          if (overflow) begin
            fault_d = 1'b1;
            code_d  = FaultOverflow;
            state_d = StHalt;
          end else if (underflow) begin
            fault_d = 1'b1;
            code_d  = FaultUnderflow;
            state_d = StHalt;
          end else begin
            state_d = StExec1;
          end
        end
      end
      StExec1: begin
        if (is_two_phase(ir_q)) state_d = StExec2;
        else if (is_mul(ir_q))  state_d = StMulw;
        else                    state_d = boundary_st;
      end
      StMulw: begin
        if (mul_done) begin
          state_d = StExec2;
        end
`ifdef CPU_SEQ_MUL_TIMEOUT_EN
        else if (mul_cnt_q == CntW'(MUL_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          code_d  = FaultMulTimeout;
          state_d = StHalt;
        end
`endif
      end
      StExec2: state_d = boundary_st;
      StHalt:  if (run && !fault_q) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == StFetch);
    ir_load   = (state_q == StFetch) && imem_ack;
    mul_start = (state_q == StExec1) && is_mul(ir_q);
    push      = (state_q == StExec1) && (ir_q == OpJms);
    pop       = (state_q == StExec1) && (ir_q == OpBbl);
    halted    = (state_q == StHalt);
    busy      = (state_q != StIdle) && (state_q != StHalt);
    if (ir_load)                   state = PhFetch;
    else if (state_q == StExec1)   state = PhExec1;
    else if (state_q == StExec2)   state = PhExec2;
    else                           state = PhNone;
  end

  assign ir         = ir_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control-state sequencer for the Harvard CPU core. Generates the one-hot {exec2, exec1, fetch} phase vector consumed by the instruction decoder, and latches the 5-bit instruction register.
- Inserts wait states for instruction-memory fetch and for the multi-cycle multiplier, so each decoder phase bit is high for exactly one cycle per instruction.
- Tracks return-stack depth for jms/bbl and halts on stack fault.

Parameters:
- STACK_DEPTH, 4, number of return-stack entries.
- DEPTH_W, 3, depth counter width; must satisfy 2**DEPTH_W > STACK_DEPTH.
- MUL_TIMEOUT, 15, maximum mul wait cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start pulse; leaves IDLE, or leaves HALT when no fault is latched.
- halt_req  in  1  stop request, honoured at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction memory has valid data on inst_in.
- inst_in  in  5  instruction opcode from program memory.
- ir  out  5  latched instruction; drives the decoder inst input.
- ir_load  out  1  one-cycle pulse when ir is captured.
- state  out  3  one-hot phase vector: [0]=fetch, [1]=exec1, [2]=exec2.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_done  in  1  multiplier result valid.
- depth  out  DEPTH_W  current return-stack occupancy.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 mul timeout.
- halted  out  1  high in HALT.
- busy  out  1  high in any state other than IDLE and HALT.

Behaviour:
- Reset: internal FSM=IDLE; all outputs 0 (state=000, ir=0, depth=0, fault=0, fault_code=00). rst overrides every other input in the same cycle.
- FSM states: IDLE, FETCH, EXEC1, MULW, EXEC2, HALT.
- Instruction classes decoded from ir:
  - jms = 00100, bbl = 00101.
  - Two-phase instructions: lda = 00011, ldr = 1110x, mul = 1101x.
- IDLE: state=000. run=1 -> FETCH.
- FETCH: imem_req=1.
  - No imem_ack: stay in FETCH, state=000.
  - On imem_ack: state=001 for that cycle only, ir<=inst_in, ir_load=1.
  - Stack check on inst_in in the ack cycle:
    - jms with depth==STACK_DEPTH -> fault, code 01, next state HALT.
    - bbl with depth==0 -> fault, code 10, next state HALT.
    - Otherwise next state EXEC1.
  - The fetch bit is still asserted in the faulting cycle, so PC advances past the faulting instruction.
- EXEC1: state=010 for exactly one cycle.
  - jms: depth+1. bbl: depth-1. These are the same cycle the decoder pushes/pops.
  - lda or ldr -> EXEC2.
  - mul -> MULW, with mul_start=1 in this EXEC1 cycle.
  - Any other instruction -> boundary.
- MULW: state=000. Stay until mul_done=1, then -> EXEC2.
  - mul_done arriving in the EXEC1 cycle is ignored; only mul_done sampled in MULW counts.
- EXEC2: state=100 for exactly one cycle -> boundary.
- Boundary rule: if halt_req=1 -> HALT, else -> FETCH.
  - halt_req is sampled only at boundaries; it never aborts an instruction mid-flight.
- HALT: state=000, halted=1.
  - run=1 with fault=0 -> FETCH.
  - With fault=1 the block stays in HALT until rst.
- run outside IDLE and HALT is ignored.
- Latency:
  - Minimum 2 cycles per one-phase instruction (FETCH, EXEC1).
  - Minimum 3 cycles for lda/ldr.
  - mul takes 3 cycles plus its mul_done wait.
- Exactly one state bit is high at a time, never more than one. state=000 in all wait, idle and halt cycles.
- The depth counter never wraps; the pre-check guarantees it stays in 0..STACK_DEPTH.

Optional Feature:
- Macro: CPU_SEQ_MUL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in MULW.
  - If MUL_TIMEOUT cycles elapse without mul_done -> fault=1, fault_code=11, -> HALT; EXEC2 is not entered.
  - The counter clears on leaving MULW.
- Undefined: MULW waits indefinitely; code 11 is never produced.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants for sta, jmp, stp, lda, jms, bbl, plus the ldr/mul/jeq prefix patterns;
  - the phase one-hot constants;
  - the fault_code enumeration;
  - the FSM state typedef.
- The decoder imports the same opcode constants.
- One natural sub-module: ret_stack_tracker, containing the depth counter and the full/empty pre-check.

Test Plan:
- Reset, pulse run, imem_ack held high, stream 00001 (jmp) -> state sequence 001,010,001,010; ir_load pulses once per fetch; depth=0.
- Stream lda with imem_ack delayed 3 cycles -> state=000 for 3 cycles then 001,010,100; ir=00011.
- Issue mul, mul_done returned 5 cycles after mul_start -> 001,010, five cycles of 000, then 100; mul_start high exactly one cycle.
- With STACK_DEPTH=4: five consecutive jms -> depth reaches 4; fifth fetch gives fault=1, fault_code=01, halted=1, no exec1 pulse; a subsequent run is ignored.
- bbl at depth 0 -> fault_code=10, HALT. Separately, assert halt_req during MULW -> instruction completes through EXEC2, then HALT with fault=0; run resumes at FETCH.
- With CPU_SEQ_MUL_TIMEOUT_EN defined, mul_done never asserted -> after 15 MULW cycles fault_code=11, halted=1. Apply rst mid-EXEC1 -> next cycle state=000, depth=0, FSM IDLE.
